// File: rtl/ifft_butterfly_unit_pkg.sv
`default_nettype none
// ifft_butterfly_unit_pkg: shared widths, rounding and saturation constants.
// Rev 1.0
package ifft_butterfly_unit_pkg;

  localparam int DATA_W     = 16;
  localparam int TW_W       = 16;
  localparam int TW_ADDR_W  = 4;

  localparam int ROUND_HALF = 2 ** 15;
  localparam int SAT_MAX    = 32767;
  localparam int SAT_MIN    = -32768;

  typedef struct packed {
    logic signed [TW_W-1:0] c;
    logic signed [TW_W-1:0] s;
  } twiddle_t;

endpackage
`default_nettype wire

// File: rtl/ifft_butterfly_unit_twiddle_rom.sv
`default_nettype none
// ifft_twiddle_rom: k -> conj(W_32^k) = c + js, Q1.15, positive sine.
// Rev 1.0
module ifft_twiddle_rom
  import ifft_butterfly_unit_pkg::*;
(
  input  logic [TW_ADDR_W-1:0] k_i,
  output twiddle_t             tw_o
);

  localparam logic signed [15:0] COS_T [16] = '{
    16'sd32767,  16'sd32137,  16'sd30273,  16'sd27245,
    16'sd23170,  16'sd18204,  16'sd12539,  16'sd6393,
    16'sd0,     -16'sd6393,  -16'sd12539, -16'sd18204,
   -16'sd23170, -16'sd27245, -16'sd30273, -16'sd32137
  };

  localparam logic signed [15:0] SIN_T [16] = '{
    16'sd0,      16'sd6393,   16'sd12539,  16'sd18204,
    16'sd23170,  16'sd27245,  16'sd30273,  16'sd32137,
    16'sd32767,  16'sd32137,  16'sd30273,  16'sd27245,
    16'sd23170,  16'sd18204,  16'sd12539,  16'sd6393
  };

  assign tw_o.c = COS_T[k_i];
  assign tw_o.s = SIN_T[k_i];

endmodule
`default_nettype wire

// File: rtl/ifft_butterfly_unit.sv
`default_nettype none
// ifft_butterfly_unit: 3-stage radix-2 DIF inverse butterfly, A'=(A+B)/2, B'=(A-B)conj(W)/2.
// Rev 1.0
module ifft_butterfly_unit #(
  parameter int DATA_W    = ifft_butterfly_unit_pkg::DATA_W,
  parameter int TW_W      = ifft_butterfly_unit_pkg::TW_W,
  parameter int TW_ADDR_W = ifft_butterfly_unit_pkg::TW_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic signed [DATA_W-1:0] i_data_ra,
  input  logic signed [DATA_W-1:0] i_data_ca,
  input  logic signed [DATA_W-1:0] i_data_rb,
  input  logic signed [DATA_W-1:0] i_data_cb,
  input  logic [TW_ADDR_W-1:0]     i_twiddle_num,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic signed [DATA_W-1:0] o_data_ra,
  output logic signed [DATA_W-1:0] o_data_ca,
  output logic signed [DATA_W-1:0] o_data_rb,
  output logic signed [DATA_W-1:0] o_data_cb,
  output logic                     o_overflow
);

  import ifft_butterfly_unit_pkg::*;

  localparam int SUM_W  = DATA_W + 1;
  localparam int PROD_W = SUM_W + TW_W + 1;
  localparam int RND_W  = PROD_W - TW_W;

  logic w_en;
  assign w_en    = !o_valid || o_ready;
  assign i_ready = w_en;

  // Stage 1: sums/differences plus twiddle, all behind the same enable
  twiddle_t                 w_tw;
  logic signed [SUM_W-1:0]  sr1_d, si1_d, dr1_d, di1_d;
  logic signed [SUM_W-1:0]  sr1_q, si1_q, dr1_q, di1_q;
  logic signed [TW_W-1:0]   c1_q, s1_q;
  logic                     v1_q;

  ifft_twiddle_rom u_rom (
    .k_i  (i_twiddle_num),
    .tw_o (w_tw)
  );

  assign sr1_d = SUM_W'(i_data_ra) + SUM_W'(i_data_rb);
  assign si1_d = SUM_W'(i_data_ca) + SUM_W'(i_data_cb);
  assign dr1_d = SUM_W'(i_data_ra) - SUM_W'(i_data_rb);
  assign di1_d = SUM_W'(i_data_ca) - SUM_W'(i_data_cb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      sr1_q <= '0;
      si1_q <= '0;
      dr1_q <= '0;
      di1_q <= '0;
      c1_q  <= '0;
      s1_q  <= '0;
    end else if (w_en) begin
      v1_q <= i_valid;
      if (i_valid) begin
        sr1_q <= sr1_d;
        si1_q <= si1_d;
        dr1_q <= dr1_d;
        di1_q <= di1_d;
        c1_q  <= w_tw.c;
        s1_q  <= w_tw.s;
      end
    end
  end

  // Stage 2: complex multiply by conj(W)
  logic signed [PROD_W-1:0] w_dr_x, w_di_x, w_c_x, w_s_x;
  logic signed [PROD_W-1:0] pr2_d, pi2_d, pr2_q, pi2_q;
  logic signed [SUM_W-1:0]  sr2_q, si2_q;
  logic                     v2_q;

  assign w_dr_x = PROD_W'(dr1_q);
  assign w_di_x = PROD_W'(di1_q);
  assign w_c_x  = PROD_W'(c1_q);
  assign w_s_x  = PROD_W'(s1_q);
  assign pr2_d  = w_dr_x * w_c_x - w_di_x * w_s_x;
  assign pi2_d  = w_dr_x * w_s_x + w_di_x * w_c_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q  <= 1'b0;
      sr2_q <= '0;
      si2_q <= '0;
      pr2_q <= '0;
      pi2_q <= '0;
    end else if (w_en) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sr2_q <= sr1_q;
        si2_q <= si1_q;
        pr2_q <= pr2_d;
        pi2_q <= pi2_d;
      end
    end
  end

  // Stage 3: halve sums, round-half-up and saturate products
  logic signed [PROD_W-1:0] w_pr_rnd, w_pi_rnd;
  logic signed [RND_W-1:0]  w_br_sh, w_bi_sh;
  logic                     w_clip_r, w_clip_i;
  logic signed [DATA_W-1:0] ar3_d, ai3_d, br3_d, bi3_d;
  logic signed [DATA_W-1:0] ar3_q, ai3_q, br3_q, bi3_q;
  logic                     ovf3_q, v3_q;

  assign ar3_d    = DATA_W'((sr2_q + SUM_W'(1)) >>> 1);
  assign ai3_d    = DATA_W'((si2_q + SUM_W'(1)) >>> 1);
  assign w_pr_rnd = pr2_q + PROD_W'(ROUND_HALF);
  assign w_pi_rnd = pi2_q + PROD_W'(ROUND_HALF);
  assign w_br_sh  = RND_W'(w_pr_rnd >>> TW_W);
  assign w_bi_sh  = RND_W'(w_pi_rnd >>> TW_W);

  // Fits in DATA_W only when every bit above the sign position agrees with it
  assign w_clip_r = !((&w_br_sh[RND_W-1:DATA_W-1]) || !(|w_br_sh[RND_W-1:DATA_W-1]));
  assign w_clip_i = !((&w_bi_sh[RND_W-1:DATA_W-1]) || !(|w_bi_sh[RND_W-1:DATA_W-1]));

  assign br3_d = !w_clip_r ? w_br_sh[DATA_W-1:0] :
                 (w_br_sh[RND_W-1] ? DATA_W'(SAT_MIN) : DATA_W'(SAT_MAX));
  assign bi3_d = !w_clip_i ? w_bi_sh[DATA_W-1:0] :
                 (w_bi_sh[RND_W-1] ? DATA_W'(SAT_MIN) : DATA_W'(SAT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q   <= 1'b0;
      ar3_q  <= '0;
      ai3_q  <= '0;
      br3_q  <= '0;
      bi3_q  <= '0;
      ovf3_q <= 1'b0;
    end else if (w_en) begin
      v3_q <= v2_q;
      if (v2_q) begin
        ar3_q  <= ar3_d;
        ai3_q  <= ai3_d;
        br3_q  <= br3_d;
        bi3_q  <= bi3_d;
        ovf3_q <= w_clip_r || w_clip_i;
      end
    end
  end

  assign o_valid    = v3_q;
  assign o_data_ra  = ar3_q;
  assign o_data_ca  = ai3_q;
  assign o_data_rb  = br3_q;
  assign o_data_cb  = bi3_q;
  assign o_overflow = ovf3_q;

endmodule
`default_nettype wire

// File: tb/tb_ifft_butterfly_unit.sv
`default_nettype none
// tb_ifft_butterfly_unit: scoreboard bench for the inverse DIF butterfly.
// Rev 1.0
`timescale 1ns/1ps
module tb_ifft_butterfly_unit;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_valid;
  logic               i_ready;
  logic signed [15:0] i_data_ra, i_data_ca, i_data_rb, i_data_cb;
  logic [3:0]         i_twiddle_num;
  logic               o_valid;
  logic               o_ready;
  logic signed [15:0] o_data_ra, o_data_ca, o_data_rb, o_data_cb;
  logic               o_overflow;

  typedef struct {
    int ra; int ca; int rb; int cb; int ovf;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ifft_butterfly_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (i_valid),
    .i_ready       (i_ready),
    .i_data_ra     (i_data_ra),
    .i_data_ca     (i_data_ca),
    .i_data_rb     (i_data_rb),
    .i_data_cb     (i_data_cb),
    .i_twiddle_num (i_twiddle_num),
    .o_valid       (o_valid),
    .o_ready       (o_ready),
    .o_data_ra     (o_data_ra),
    .o_data_ca     (o_data_ca),
    .o_data_rb     (o_data_rb),
    .o_data_cb     (o_data_cb),
    .o_overflow    (o_overflow)
  );

  task automatic chk(input string nm, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Reference: exact integer arithmetic with twiddles derived from real cos/sin
  function automatic exp_t model(input int ra, input int ca, input int rb, input int cb, input int k);
    exp_t   e;
    real    ang;
    longint c, s, dr, di, pr, pi, br, bi;
    ang  = 2.0 * 3.14159265358979 * k / 32.0;
    c    = rnd(32767.0 * $cos(ang));
    s    = rnd(32767.0 * $sin(ang));
    e.ra = (ra + rb + 1) >>> 1;
    e.ca = (ca + cb + 1) >>> 1;
    dr   = ra - rb;
    di   = ca - cb;
    pr   = dr * c - di * s;
    pi   = dr * s + di * c;
    br   = (pr + 32768) >>> 16;
    bi   = (pi + 32768) >>> 16;
    e.ovf = 0;
    if (br > 32767)  begin br = 32767;  e.ovf = 1; end
    if (br < -32768) begin br = -32768; e.ovf = 1; end
    if (bi > 32767)  begin bi = 32767;  e.ovf = 1; end
    if (bi < -32768) begin bi = -32768; e.ovf = 1; end
    e.rb = int'(br);
    e.cb = int'(bi);
    return e;
  endfunction

  // Monitor: an output transfers at the next rising edge when valid && ready here
  always @(negedge clk) begin
    if (rst_n && o_valid && o_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_ra", o_data_ra, e.ra);
        chk("out_ca", o_data_ca, e.ca);
        chk("out_rb", o_data_rb, e.rb);
        chk("out_cb", o_data_cb, e.cb);
        chk("out_ovf", o_overflow, e.ovf);
      end
    end
  end

  task automatic send(input int ra, input int ca, input int rb, input int cb,
                      input int k, input exp_t e);
    bit acc = 0;
    i_data_ra     = 16'(ra);
    i_data_ca     = 16'(ca);
    i_data_rb     = 16'(rb);
    i_data_cb     = 16'(cb);
    i_twiddle_num = 4'(k);
    i_valid       = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (i_ready) begin
        sbq.push_back(e);
        acc = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && sbq.size() != 0; t++) @(posedge clk);
    chk("drain_empty", sbq.size(), 0);
    #1;
  endtask

  function automatic exp_t mk(input int ra, input int ca, input int rb, input int cb, input int ovf);
    exp_t e;
    e.ra = ra; e.ca = ca; e.rb = rb; e.cb = cb; e.ovf = ovf;
    return e;
  endfunction

  int stream_v [6][5] = '{
    '{100, -50, 30, 20, 0},
    '{-1200, 300, 400, -700, 3},
    '{5000, 5000, -5000, 5000, 12},
    '{32767, -32768, -32768, 32767, 2},
    '{-20000, 15000, -20000, -15000, 15},
    '{123, -456, 789, -1011, 9}
  };

  initial begin
    int lat;
    rst_n         = 1'b0;
    o_ready       = 1'b1;
    i_valid       = 1'($urandom);
    i_data_ra     = 16'($urandom);
    i_data_ca     = 16'($urandom);
    i_data_rb     = 16'($urandom);
    i_data_cb     = 16'($urandom);
    i_twiddle_num = 4'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_ra", o_data_ra, 0);
    chk("rst_ca", o_data_ca, 0);
    chk("rst_rb", o_data_rb, 0);
    chk("rst_cb", o_data_cb, 0);
    @(posedge clk); #1;
    i_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("rst_i_ready", i_ready, 1);
    @(posedge clk); #1;

    // k=0 with latency measurement
    send(1000, 0, 200, 0, 0, mk(600, 0, 400, 0, 0));
    lat = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      lat++;
      if (o_valid) break;
    end
    chk("latency_edges", lat, 3);
    drain();

    send(2000, 0, 0, 0, 8, mk(1000, 0, 0, 1000, 0));
    drain();

    send(32767, 32767, -32768, -32768, 4, mk(0, 0, 0, 32767, 1));
    drain();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("hold_valid_low", o_valid, 0);
    chk("hold_cb", o_data_cb, 32767);
    chk("hold_ovf", o_overflow, 1);
    @(posedge clk); #1;

    // Back-pressure: 6 back-to-back pairs, 4-cycle stall after first output
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(stream_v[i][0], stream_v[i][1], stream_v[i][2], stream_v[i][3], stream_v[i][4],
               model(stream_v[i][0], stream_v[i][1], stream_v[i][2], stream_v[i][3], stream_v[i][4]));
      end
      begin
        logic signed [15:0] snap [4];
        bit seen = 0;
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (o_valid) begin seen = 1; break; end
        end
        if (!seen) chk("stall_first_out_timeout", 0, 1);
        @(posedge clk); #1;
        o_ready = 1'b0;
        @(negedge clk);
        snap[0] = o_data_ra; snap[1] = o_data_ca; snap[2] = o_data_rb; snap[3] = o_data_cb;
        chk("stall_o_valid", o_valid, 1);
        for (int c = 0; c < 4; c++) begin
          if (c > 0) @(negedge clk);
          chk("stall_i_ready", i_ready, 0);
          chk("stall_ra_frozen", o_data_ra, snap[0]);
          chk("stall_rb_frozen", o_data_rb, snap[2]);
        end
        @(posedge clk); #1;
        o_ready = 1'b1;
      end
    join
    drain();

    // Reset with three samples in flight
    send(111, 222, 333, 444, 1, model(111, 222, 333, 444, 1));
    send(-5, 6, 7, -8, 5, model(-5, 6, 7, -8, 5));
    send(900, -900, 100, 100, 7, model(900, -900, 100, 100, 7));
    rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_ra", o_data_ra, 0);
    chk("midrst_cb", o_data_cb, 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_no_stale", o_valid, 0);
    end
    @(posedge clk); #1;
    send(1000, 0, 200, 0, 0, mk(600, 0, 400, 0, 0));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
